// File: rtl/turn_scheduler.sv
// Tic-tac-toe move sequencer: alternates X/O turns, validates moves, drives the cell decoder select.
// Optional line-win detection is built only when WIN_DETECT_EN is defined.
module turn_scheduler #(
  parameter logic [3:0] IDLE_SEL     = 4'd15,
  parameter logic       FIRST_PLAYER = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       req_x,
  input  logic [3:0] cell_x,
  input  logic       req_o,
  input  logic [3:0] cell_o,
  output logic [3:0] sel,
  output logic       wr_en,
  output logic       wr_player,
  output logic       grant_x,
  output logic       grant_o,
  output logic       reject,
  output logic       turn,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic [3:0] move_count,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {S_IDLE, S_TURN, S_COMMIT, S_CHECK, S_DONE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] cell_reg, cell_next;
  logic       turn_reg, turn_next;
  logic [8:0] board_x_reg, board_x_next;
  logic [8:0] board_o_reg, board_o_next;
  logic [3:0] count_reg, count_next;
  logic [1:0] winner_reg, winner_next;
  logic       arm_x_reg, arm_x_next;
  logic       arm_o_reg, arm_o_next;
  logic       reject_reg, reject_next;

  logic       req_cur, arm_cur, illegal, win;
  logic [3:0] cell_cur;
  logic [8:0] cur_mask, commit_mask;

  assign req_cur     = turn_reg ? req_o  : req_x;
  assign cell_cur    = turn_reg ? cell_o : cell_x;
  assign arm_cur     = turn_reg ? arm_o_reg : arm_x_reg;
  // Cells 9-15 shift the one-hot mask out entirely; the range test catches them.
  assign cur_mask    = 9'd1 << cell_cur;
  assign commit_mask = 9'd1 << cell_reg;
  assign illegal     = (cell_cur > 4'd8) || (|(cur_mask & (board_x_reg | board_o_reg)));

`ifdef WIN_DETECT_EN
  logic [8:0] board_cur;
  assign board_cur = turn_reg ? board_o_reg : board_x_reg;
  assign win = (&board_cur[2:0]) | (&board_cur[5:3]) | (&board_cur[8:6])
             | (board_cur[0] & board_cur[3] & board_cur[6])
             | (board_cur[1] & board_cur[4] & board_cur[7])
             | (board_cur[2] & board_cur[5] & board_cur[8])
             | (board_cur[0] & board_cur[4] & board_cur[8])
             | (board_cur[2] & board_cur[4] & board_cur[6]);
`else
  assign win = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    cell_next    = cell_reg;
    turn_next    = turn_reg;
    board_x_next = board_x_reg;
    board_o_next = board_o_reg;
    count_next   = count_reg;
    winner_next  = winner_reg;
    reject_next  = 1'b0;
    // A request seen low re-arms that player, so a held request is evaluated once.
    arm_x_next   = arm_x_reg | ~req_x;
    arm_o_next   = arm_o_reg | ~req_o;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next   = S_TURN;
          board_x_next = 9'd0;
          board_o_next = 9'd0;
          count_next   = 4'd0;
          winner_next  = 2'b00;
          turn_next    = FIRST_PLAYER;
        end
      end
      S_TURN: begin
        if (req_cur && arm_cur) begin
          if (turn_reg) arm_o_next = 1'b0;
          else          arm_x_next = 1'b0;
          if (illegal) begin
            reject_next = 1'b1;
          end else begin
            cell_next  = cell_cur;
            state_next = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        if (turn_reg) board_o_next = board_o_reg | commit_mask;
        else          board_x_next = board_x_reg | commit_mask;
        count_next = (count_reg >= 4'd9) ? 4'd9 : count_reg + 4'd1;
        state_next = S_CHECK;
      end
      S_CHECK: begin
        if (win) begin
          winner_next = turn_reg ? 2'b10 : 2'b01;
          state_next  = S_DONE;
        end else if (count_reg == 4'd9) begin
          winner_next = 2'b11;
          state_next  = S_DONE;
        end else begin
          turn_next  = ~turn_reg;
          state_next = S_TURN;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      cell_reg    <= 4'd0;
      turn_reg    <= FIRST_PLAYER;
      board_x_reg <= 9'd0;
      board_o_reg <= 9'd0;
      count_reg   <= 4'd0;
      winner_reg  <= 2'b00;
      arm_x_reg   <= 1'b1;
      arm_o_reg   <= 1'b1;
      reject_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cell_reg    <= cell_next;
      turn_reg    <= turn_next;
      board_x_reg <= board_x_next;
      board_o_reg <= board_o_next;
      count_reg   <= count_next;
      winner_reg  <= winner_next;
      arm_x_reg   <= arm_x_next;
      arm_o_reg   <= arm_o_next;
      reject_reg  <= reject_next;
    end
  end

  assign wr_en      = (state_reg == S_COMMIT);
  assign sel        = wr_en ? cell_reg : IDLE_SEL;
  assign wr_player  = turn_reg;
  assign grant_x    = wr_en & ~turn_reg;
  assign grant_o    = wr_en & turn_reg;
  assign reject     = reject_reg;
  assign turn       = turn_reg;
  assign board_x    = board_x_reg;
  assign board_o    = board_o_reg;
  assign move_count = count_reg;
  assign game_over  = (state_reg == S_DONE);
  assign winner     = winner_reg;

endmodule

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
Sequences moves for the tic-tac-toe board and drives the cell decoder's 4-bit select, where codes 0-8 map to en1-en9 and codes 9-15 assert no enable. It grants the shared write path to players X and O in alternating turns and rejects illegal moves. It also tracks board occupancy and the move count, and declares game over.

Parameters:
IDLE_SEL, 4'd15, select value driven whenever no write is in progress (decodes to no enable)
FIRST_PLAYER, 1'b0, player to move first after start: 0 = X, 1 = O

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-low; sampled on rising clock edge
start  input  1  begin or restart a game; honoured only in IDLE or DONE
req_x  input  1  player X move request, level, held until grant_x or reject
cell_x  input  4  player X target cell, 0-8
req_o  input  1  player O move request, level
cell_o  input  4  player O target cell, 0-8
sel  output  4  to decoder sel
wr_en  output  1  one-cycle write strobe, aligned with a valid sel
wr_player  output  1  owner of the current write: 0 = X, 1 = O
grant_x  output  1  one-cycle pulse, X move accepted
grant_o  output  1  one-cycle pulse, O move accepted
reject  output  1  one-cycle pulse, move of the current player refused
turn  output  1  player whose move is awaited: 0 = X, 1 = O
board_x  output  9  occupancy by X; bit i corresponds to cell i
board_o  output  9  occupancy by O
move_count  output  4  accepted moves this game, 0-9
game_over  output  1  high in DONE
winner  output  2  00 none, 01 X, 10 O, 11 draw

Behaviour:
- Reset (reset == 0 at a clock edge) forces the following. Takes priority over every other input, in any state including mid-COMMIT.
  - state = IDLE, sel = IDLE_SEL
  - wr_en, grant_x, grant_o, reject, game_over = 0
  - board_x = board_o = 0, move_count = 0, winner = 00
  - turn = FIRST_PLAYER
  - both arm flags = 1
- IDLE: outputs held at reset values. On start, go to TURN; board, counters and winner are cleared.
- TURN: only the request of the player given by turn is examined, and only when that player's arm flag is 1. The other player's request is ignored: no reject, no grant. The move is evaluated at a clock edge:
  - Illegal move: cell > 8, or bit set in (board_x | board_o). Result next cycle: reject = 1 for one cycle, arm flag cleared, state stays TURN.
  - Legal move: cell latched, arm flag cleared, go to COMMIT.
- COMMIT, exactly one cycle:
  - sel = latched cell, wr_en = 1, wr_player = turn.
  - The current player's grant pulses for this same cycle.
  - At the end of the cycle the board bit is set and move_count increments.
  - Latency is one cycle from the sampling edge to wr_en and grant.
- CHECK, one cycle; sel = IDLE_SEL. Evaluates the updated board:
  - move_count == 9 with no win: winner = 11, go to DONE.
  - Otherwise: turn toggles, go to TURN.
- DONE: game_over = 1, all moves ignored, sel = IDLE_SEL. On start, clear board, move_count and winner, set turn = FIRST_PLAYER, go to TURN.
- Arm flag (one per player): set when that player's req is sampled low. A held request therefore produces exactly one grant or reject.
- Start asserted in TURN, COMMIT or CHECK is ignored.
- sel is never a value 0-8 outside COMMIT. wr_en and a grant are never asserted together with reject.
- move_count saturates at 9 and never wraps.

Optional Feature:
Macro: WIN_DETECT_EN
- Defined: CHECK also tests the 8 lines (3 rows, 3 columns, 2 diagonals) on the current player's board. A win sets winner = 01 or 10 and goes to DONE. A win takes precedence over a draw on the 9th move.
- Not defined: no line logic is built. Only a full board ends the game, with winner = 11.

Test Plan:
1. Reset held low 2 cycles, then released, then start -> all outputs at reset values, sel = 15, turn = 0, state TURN.
2. X requests cell 4 -> next cycle sel = 4, wr_en = 1, grant_x = 1, wr_player = 0; then board_x = 9'h010, move_count = 1, turn = 1.
3. O requests cell 4 (occupied), then cell 9 -> two separate reject pulses with req dropped between them; no wr_en; board unchanged; turn stays 1.
4. X and O both request together when turn = 1 -> only O is granted. X's held request is then granted after CHECK once turn = 0.
5. Nine legal non-winning moves -> move_count = 9, winner = 11, game_over = 1. A further start clears the boards and sets turn = 0.
6. With WIN_DETECT_EN: X plays 0, 1, 2 interleaved with O playing 3, 4 -> winner = 01 after X's third move, game_over = 1. Reset asserted during a COMMIT -> wr_en = 0 on the next cycle and the boards cleared.
